// File: rtl/rat_pkg.sv
// Shared types for the maze rat: move encoding, tracker FSM states and error codes.
package rat_pkg;

    typedef enum logic [1:0] {
        MV_UP    = 2'b00,
        MV_RIGHT = 2'b01,
        MV_DOWN  = 2'b10,
        MV_LEFT  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_DONE,
        ST_ERROR
    } trk_state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OOB   = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_EXTRA = 2'd3;

endpackage

// File: rtl/rat_step_calc.sv
// Combinational single-step position update with grid bound check (no wrap-around).
module rat_step_calc
    import rat_pkg::*;
#(
    parameter int GRID_H = 16,
    parameter int GRID_W = 16,
    parameter int ROW_W  = $clog2(GRID_H),
    parameter int COL_W  = $clog2(GRID_W)
) (
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    input  move_t            move,
    output logic [ROW_W-1:0] next_row,
    output logic [COL_W-1:0] next_col,
    output logic             oob
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_H - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_W - 1);

    // Bound is checked against the current position so an edge move never wraps.
    always_comb begin
        next_row = row;
        next_col = col;
        oob      = 1'b0;
        unique case (move)
            MV_UP: begin
                if (row == '0) oob = 1'b1;
                else next_row = row - ROW_W'(1);
            end
            MV_RIGHT: begin
                if (col >= COL_MAX) oob = 1'b1;
                else next_col = col + COL_W'(1);
            end
            MV_DOWN: begin
                if (row >= ROW_MAX) oob = 1'b1;
                else next_row = row + ROW_W'(1);
            end
            MV_LEFT: begin
                if (col == '0) oob = 1'b1;
                else next_col = col - COL_W'(1);
            end
        endcase
    end

endmodule

// File: rtl/rat_path_tracker.sv
// Follows the solver's replayed moves, tracking position and step count and
// flagging arrival at the goal or any path error.
module rat_path_tracker
    import rat_pkg::*;
#(
    parameter int GRID_H    = 16,
    parameter int GRID_W    = 16,
    parameter int START_ROW = 0,
    parameter int START_COL = 0,
    parameter int GOAL_ROW  = GRID_H - 1,
    parameter int GOAL_COL  = GRID_W - 1,
    parameter int STEP_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      move_valid,
    input  logic [1:0]                move,
    input  logic                      move_last,
    output logic                      move_ready,
    output logic [$clog2(GRID_H)-1:0] row,
    output logic [$clog2(GRID_W)-1:0] col,
    output logic [STEP_W-1:0]         step_count,
    output logic                      busy,
    output logic                      arrived,
    output logic                      err,
    output logic [1:0]                err_code
);

    localparam int ROW_W = $clog2(GRID_H);
    localparam int COL_W = $clog2(GRID_W);

    localparam logic [ROW_W-1:0] START_R = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0] START_C = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] GOAL_R  = ROW_W'(GOAL_ROW);
    localparam logic [COL_W-1:0] GOAL_C  = COL_W'(GOAL_COL);

    trk_state_t       state;
    logic [ROW_W-1:0] next_row;
    logic [COL_W-1:0] next_col;
    logic             step_oob;

    rat_step_calc #(
        .GRID_H (GRID_H),
        .GRID_W (GRID_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_step (
        .row      (row),
        .col      (col),
        .move     (move_t'(move)),
        .next_row (next_row),
        .next_col (next_col),
        .oob      (step_oob)
    );

    assign move_ready = (state == ST_TRACK);
    assign busy       = (state == ST_TRACK);

    // start outranks everything but reset, so a move offered alongside it is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            row        <= '0;
            col        <= '0;
            step_count <= '0;
            arrived    <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else if (start) begin
            state      <= ST_TRACK;
            row        <= START_R;
            col        <= START_C;
            step_count <= '0;
            arrived    <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            case (state)
                ST_TRACK: begin
                    if (move_valid) begin
                        if (step_oob) begin
                            err      <= 1'b1;
                            err_code <= ERR_OOB;
                            state    <= ST_ERROR;
                        end else begin
                            row <= next_row;
                            col <= next_col;
                            if (step_count != '1) step_count <= step_count + STEP_W'(1);
                            // Reaching the goal wins over move_last; later moves are caught in DONE.
                            if (next_row == GOAL_R && next_col == GOAL_C) begin
                                arrived <= 1'b1;
                                state   <= ST_DONE;
                            end else if (move_last) begin
                                err      <= 1'b1;
                                err_code <= ERR_SHORT;
                                state    <= ST_ERROR;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (move_valid) begin
                        err      <= 1'b1;
                        err_code <= ERR_EXTRA;
                        state    <= ST_ERROR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rat_path_tracker.sv
// Directed bench for rat_path_tracker: a reference model pushes expected
// results to a scoreboard queue that is popped after each DUT update.
module tb_rat_path_tracker;

    localparam int STEP_MAX = 255;

    typedef struct {
        string      tag;
        logic [3:0] row;
        logic [3:0] col;
        logic [7:0] step;
        logic       busy;
        logic       arrived;
        logic       err;
        logic [1:0] code;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       move_valid;
    logic [1:0] move;
    logic       move_last;
    logic       move_ready;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] step_count;
    logic       busy;
    logic       arrived;
    logic       err;
    logic [1:0] err_code;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t sb[$];

    // Model state: 0 idle, 1 track, 2 done, 3 error
    int         m_state;
    int         m_row, m_col, m_step;
    logic       m_arr, m_err;
    logic [1:0] m_code;

    rat_path_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .move_valid (move_valid),
        .move       (move),
        .move_last  (move_last),
        .move_ready (move_ready),
        .row        (row),
        .col        (col),
        .step_count (step_count),
        .busy       (busy),
        .arrived    (arrived),
        .err        (err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_expected(input string tag);
        exp_t e;
        e.tag     = tag;
        e.row     = 4'(m_row);
        e.col     = 4'(m_col);
        e.step    = 8'(m_step);
        e.busy    = (m_state == 1);
        e.arrived = m_arr;
        e.err     = m_err;
        e.code    = m_code;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input bit full);
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (full) begin
            cmp({e.tag, ".row"},  32'(row),        32'(e.row));
            cmp({e.tag, ".col"},  32'(col),        32'(e.col));
            cmp({e.tag, ".step"}, 32'(step_count), 32'(e.step));
            cmp({e.tag, ".code"}, 32'(err_code),   32'(e.code));
        end
        cmp({e.tag, ".err"},     32'(err),        32'(e.err));
        cmp({e.tag, ".arrived"}, 32'(arrived),    32'(e.arrived));
        cmp({e.tag, ".busy"},    32'(busy),       32'(e.busy));
        cmp({e.tag, ".ready"},   32'(move_ready), 32'(e.busy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init(input bit idle);
        m_state = idle ? 0 : 1;
        m_row   = 0;
        m_col   = 0;
        m_step  = 0;
        m_arr   = 1'b0;
        m_err   = 1'b0;
        m_code  = 2'd0;
    endtask

    task automatic model_move(input logic [1:0] mv, input bit last);
        int nr, nc;
        if (m_state == 1) begin
            nr = m_row + ((mv == 2'd2) ? 1 : (mv == 2'd0) ? -1 : 0);
            nc = m_col + ((mv == 2'd1) ? 1 : (mv == 2'd3) ? -1 : 0);
            if (nr < 0 || nr > 15 || nc < 0 || nc > 15) begin
                m_err = 1'b1; m_code = 2'd1; m_state = 3;
            end else begin
                m_row = nr;
                m_col = nc;
                if (m_step < STEP_MAX) m_step++;
                if (nr == 15 && nc == 15) begin
                    m_arr = 1'b1; m_state = 2;
                end else if (last) begin
                    m_err = 1'b1; m_code = 2'd2; m_state = 3;
                end
            end
        end else if (m_state == 2) begin
            m_err = 1'b1; m_code = 2'd3; m_state = 3;
        end
    endtask

    // Offers one move for exactly one clock edge.
    task automatic applyStimulus(input string tag, input logic [1:0] mv, input bit last, input bit full);
        model_move(mv, last);
        push_expected(tag);
        move_valid = 1'b1;
        move       = mv;
        move_last  = last;
        tick();
        move_valid = 1'b0;
        move_last  = 1'b0;
        checkOutput(full);
    endtask

    task automatic do_start(input string tag, input bit with_move);
        model_init(1'b0);
        push_expected(tag);
        start = 1'b1;
        if (with_move) begin
            move_valid = 1'b1;
            move       = 2'd1;
        end
        tick();
        start      = 1'b0;
        move_valid = 1'b0;
        checkOutput(1'b1);
    endtask

    task automatic do_reset(input string tag);
        model_init(1'b1);
        push_expected(tag);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput(1'b1);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        move_valid = 1'b0;
        move       = 2'd0;
        move_last  = 1'b0;
        model_init(1'b1);
        tick();
        do_reset("reset");

        // Full path to the goal
        do_start("start1", 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus("p1_right", 2'd1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) applyStimulus("p1_down", 2'd2, (i == 14), 1'b1);

        // Move after arrival
        applyStimulus("extra_left", 2'd3, 1'b0, 1'b1);

        // Out of bounds at the origin
        do_start("start2", 1'b0);
        applyStimulus("oob_up", 2'd0, 1'b0, 1'b1);
        push_expected("err_hold");
        tick();
        checkOutput(1'b1);

        // Path ends short of the goal
        do_start("start3", 1'b0);
        applyStimulus("short_d1", 2'd2, 1'b0, 1'b1);
        applyStimulus("short_d2", 2'd2, 1'b0, 1'b1);
        applyStimulus("short_r",  2'd1, 1'b1, 1'b1);

        // Reset mid-path, then start with a simultaneous move
        do_start("start4", 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("mid_down", 2'd2, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus("mid_right", 2'd1, 1'b0, 1'b1);
        do_reset("mid_reset");
        do_start("start_with_move", 1'b1);
        push_expected("after_start_move");
        tick();
        checkOutput(1'b1);

        // Long back-and-forth run with random gaps; step count saturates
        do_start("start5", 1'b0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus("osc", (i % 2 == 0) ? 2'd1 : 2'd3, 1'b0, (i % 20 == 0));
            repeat ($urandom_range(1, 3)) begin
                push_expected("osc_gap");
                tick();
                checkOutput(1'b0);
            end
        end
        cmp("sat_step", 32'(step_count), 32'd255);
        cmp("sat_col",  32'(col),        32'd0);
        cmp("sat_err",  32'(err),        32'd0);

        if (sb.size() != 0) cmp("scoreboard_leftover", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
